// File: rtl/pixel_layer_scheduler_if.sv
// Pixel-stream bundle between the VGA fetch logic, the layer scheduler and the colour mapper.
interface pixel_layer_scheduler_if;
    logic       pixel_en;
    logic       frame_start;
    logic [4:0] bg_index;
    logic       spr_valid;
    logic [4:0] spr_index;
    logic       blt_valid;
    logic [4:0] blt_index;
    logic       flash_req;
    logic [4:0] memMappedValue;
    logic       out_valid;
    logic       flash_active;
    logic       range_err;

    modport master (
        output pixel_en, frame_start, bg_index, spr_valid, spr_index,
               blt_valid, blt_index, flash_req,
        input  memMappedValue, out_valid, flash_active, range_err
    );

    modport slave (
        input  pixel_en, frame_start, bg_index, spr_valid, spr_index,
               blt_valid, blt_index, flash_req,
        output memMappedValue, out_valid, flash_active, range_err
    );
endinterface

// File: rtl/pixel_layer_scheduler.sv
// Two-stage layer arbiter (bullet > sprite > background) with a frame-timed sprite hit-flash.
//   state     | meaning
//   IDLE      | no flash event; a flash_req is latched as pending
//   FLASH_ON  | sprite pixels replaced by FLASH_INDEX
//   FLASH_OFF | sprite pixels shown normally between flash-on phases
module pixel_layer_scheduler #(
    parameter logic [4:0]  MAX_INDEX    = 5'h15,
    parameter logic [4:0]  FLASH_INDEX  = 5'h06,
    parameter int unsigned FLASH_FRAMES = 4,
    parameter int unsigned FLASH_CYCLES = 3
) (
    input logic                    Clk,
    input logic                    Reset,
    pixel_layer_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

    localparam logic [3:0] FRM_LAST = 4'(FLASH_FRAMES - 1);
    localparam logic [2:0] CYC_LAST = 3'(FLASH_CYCLES - 1);

    flash_state_t state, state_next;
    logic         pending, pending_next;
    logic [3:0]   frm_cnt, frm_cnt_next;
    logic [2:0]   cyc_cnt, cyc_cnt_next;

    logic       s1_valid;
    logic [4:0] s1_bg_index;
    logic       s1_spr_valid;
    logic [4:0] s1_spr_index;
    logic       s1_blt_valid;
    logic [4:0] s1_blt_index;

    logic [4:0] win_index;
    logic       spr_win;
    logic       out_of_range;
    logic [4:0] resolved;

    logic [4:0] mapped_value;
    logic       out_valid_r;
    logic       range_err_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            frm_cnt <= 4'd0;
            cyc_cnt <= 3'd0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            frm_cnt <= frm_cnt_next;
            cyc_cnt <= cyc_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        frm_cnt_next = frm_cnt;
        cyc_cnt_next = cyc_cnt;
        case (state)
            IDLE: begin
                if (bus.frame_start && (pending || bus.flash_req)) begin
                    state_next   = FLASH_ON;
                    pending_next = 1'b0;
                    frm_cnt_next = 4'd0;
                    cyc_cnt_next = 3'd0;
                end else if (bus.flash_req) begin
                    pending_next = 1'b1;
                end
            end
            FLASH_ON: begin
                if (bus.frame_start) begin
                    if (frm_cnt == FRM_LAST) begin
                        frm_cnt_next = 4'd0;
                        state_next   = FLASH_OFF;
                    end else begin
                        frm_cnt_next = frm_cnt + 4'd1;
                    end
                end
            end
            FLASH_OFF: begin
                if (bus.frame_start) begin
                    if (frm_cnt == FRM_LAST) begin
                        frm_cnt_next = 4'd0;
                        if (cyc_cnt == CYC_LAST) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = FLASH_ON;
                            cyc_cnt_next = cyc_cnt + 3'd1;
                        end
                    end else begin
                        frm_cnt_next = frm_cnt + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid     <= 1'b0;
            s1_bg_index  <= 5'd0;
            s1_spr_valid <= 1'b0;
            s1_spr_index <= 5'd0;
            s1_blt_valid <= 1'b0;
            s1_blt_index <= 5'd0;
        end else begin
            s1_valid     <= bus.pixel_en;
            s1_bg_index  <= bus.bg_index;
            s1_spr_valid <= bus.spr_valid;
            s1_spr_index <= bus.spr_index;
            s1_blt_valid <= bus.blt_valid;
            s1_blt_index <= bus.blt_index;
        end
    end

    // Flash override is applied after the range check, so a flashed sprite is never blanked.
    always_comb begin
        spr_win   = 1'b0;
        win_index = s1_bg_index;
        if (s1_blt_valid && (s1_blt_index != 5'd0)) begin
            win_index = s1_blt_index;
        end else if (s1_spr_valid && (s1_spr_index != 5'd0)) begin
            win_index = s1_spr_index;
            spr_win   = 1'b1;
        end
        out_of_range = (win_index > MAX_INDEX);
        resolved     = out_of_range ? 5'd0 : win_index;
        if (spr_win && (state == FLASH_ON)) begin
            resolved = FLASH_INDEX;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mapped_value <= 5'd0;
            out_valid_r  <= 1'b0;
            range_err_r  <= 1'b0;
        end else begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                mapped_value <= resolved;
                if (out_of_range) begin
                    range_err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.memMappedValue = mapped_value;
    assign bus.out_valid      = out_valid_r;
    assign bus.range_err      = range_err_r;
    assign bus.flash_active   = (state != IDLE);

endmodule

// File: tb/tb_pixel_layer_scheduler.sv
// Bench for pixel_layer_scheduler: directed vector table, flash/reset sequences and a randomized run.
module tb_pixel_layer_scheduler;

    localparam logic [4:0] MAX_IDX = 5'h15;
    localparam logic [4:0] FL_IDX  = 5'h06;
    localparam int         FF      = 4;
    localparam int         FC      = 3;

    logic Clk;
    logic Reset;
    pixel_layer_scheduler_if bus ();

    pixel_layer_scheduler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: flash timing is tracked as "frames since event start".
    int         evt_k = -1;
    bit         pend  = 0;
    bit         p_v   = 0;
    logic [4:0] p_val = 5'd0;
    bit         p_err = 0;
    bit         m_ov  = 0;
    logic [4:0] m_val = 5'd0;
    bit         m_err = 0;

    typedef struct {
        logic [4:0] bg;
        logic       sv;
        logic [4:0] spr;
        logic       bv;
        logic [4:0] blt;
        logic [4:0] exp_val;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [4:0] w;
        bit sw;
        if (Reset) begin
            evt_k = -1; pend = 0; p_v = 0; p_val = 5'd0; p_err = 0;
            m_ov = 0; m_val = 5'd0; m_err = 0;
            return;
        end
        m_ov = p_v;
        if (p_v) begin
            m_val = p_val;
            m_err = m_err | p_err;
        end
        if (evt_k < 0) begin
            if (bus.frame_start && (pend || bus.flash_req)) begin
                evt_k = 0;
                pend  = 0;
            end else if (bus.flash_req) begin
                pend = 1;
            end
        end else if (bus.frame_start) begin
            evt_k++;
            if (evt_k >= 2 * FF * FC) evt_k = -1;
        end
        p_v = bus.pixel_en;
        sw  = 0;
        w   = bus.bg_index;
        if (bus.blt_valid && bus.blt_index != 5'd0) begin
            w = bus.blt_index;
        end else if (bus.spr_valid && bus.spr_index != 5'd0) begin
            w  = bus.spr_index;
            sw = 1;
        end
        p_err = (w > MAX_IDX);
        p_val = p_err ? 5'd0 : w;
        if (sw && evt_k >= 0 && ((evt_k / FF) % 2 == 0)) p_val = FL_IDX;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        chk("model_out_valid", 8'(bus.out_valid), 8'(m_ov));
        chk("model_value", 8'(bus.memMappedValue), 8'(m_val));
        chk("model_flash_active", 8'(bus.flash_active), 8'(evt_k >= 0));
        chk("model_range_err", 8'(bus.range_err), 8'(m_err));
    endtask

    task automatic drive(input logic pe, input logic fs, input logic fr, input logic [4:0] bg,
                         input logic sv, input logic [4:0] spr, input logic bv, input logic [4:0] blt);
        bus.pixel_en    = pe;
        bus.frame_start = fs;
        bus.flash_req   = fr;
        bus.bg_index    = bg;
        bus.spr_valid   = sv;
        bus.spr_index   = spr;
        bus.blt_valid   = bv;
        bus.blt_index   = blt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit on;
        Reset = 1'b1;
        idle();

        // Reset with a pixel presented: outputs stay invalid for two cycles after release.
        drive(1, 0, 0, 5'h05, 0, 5'd0, 0, 5'd0);
        tick(); tick();
        chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_value", 8'(bus.memMappedValue), 8'd0);
        chk("rst_flash_active", 8'(bus.flash_active), 8'd0);
        chk("rst_range_err", 8'(bus.range_err), 8'd0);
        Reset = 1'b0;
        tick();
        chk("post_rst_cycle1_valid", 8'(bus.out_valid), 8'd0);
        idle();
        tick();
        chk("post_rst_cycle2_valid", 8'(bus.out_valid), 8'd1);
        chk("post_rst_cycle2_value", 8'(bus.memMappedValue), 8'h05);
        tick();
        chk("hold_valid_low", 8'(bus.out_valid), 8'd0);
        chk("hold_value", 8'(bus.memMappedValue), 8'h05);

        vecs[0] = '{5'h05, 1'b0, 5'h00, 1'b0, 5'h00, 5'h05, 1'b0};
        vecs[1] = '{5'h03, 1'b1, 5'h09, 1'b1, 5'h00, 5'h09, 1'b0};
        vecs[2] = '{5'h03, 1'b1, 5'h09, 1'b1, 5'h0A, 5'h0A, 1'b0};
        vecs[3] = '{5'h03, 1'b1, 5'h00, 1'b0, 5'h0A, 5'h03, 1'b0};
        vecs[4] = '{5'h00, 1'b0, 5'h07, 1'b0, 5'h00, 5'h00, 1'b0};
        vecs[5] = '{5'h03, 1'b0, 5'h09, 1'b0, 5'h0A, 5'h03, 1'b0};
        vecs[6] = '{5'h15, 1'b0, 5'h00, 1'b0, 5'h00, 5'h15, 1'b0};
        vecs[7] = '{5'h03, 1'b1, 5'h16, 1'b0, 5'h00, 5'h00, 1'b1};
        vecs[8] = '{5'h07, 1'b0, 5'h00, 1'b0, 5'h00, 5'h07, 1'b1};
        vecs[9] = '{5'h02, 1'b1, 5'h04, 1'b1, 5'h1F, 5'h00, 1'b1};

        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, vecs[i].bg, vecs[i].sv, vecs[i].spr, vecs[i].bv, vecs[i].blt);
            tick();
            chk($sformatf("vec%0d_latency", i), 8'(bus.out_valid), 8'd0);
            idle();
            tick();
            chk($sformatf("vec%0d_valid", i), 8'(bus.out_valid), 8'd1);
            chk($sformatf("vec%0d_value", i), 8'(bus.memMappedValue), 8'(vecs[i].exp_val));
            chk($sformatf("vec%0d_range_err", i), 8'(bus.range_err), 8'(vecs[i].exp_err));
        end

        // Flash event: request mid-frame, start on next frame_start, second request ignored.
        Reset = 1'b1; idle(); tick(); Reset = 1'b0;
        chk("flash_rst_range_err", 8'(bus.range_err), 8'd0);
        drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0);
        tick();
        chk("pending_not_active", 8'(bus.flash_active), 8'd0);
        idle(); tick();
        for (int k = 0; k < 26; k++) begin
            on = (k < 2 * FF * FC) && ((k / FF) % 2 == 0);
            drive(1, 1, (k == 5), 5'h03, 1, 5'h09, 0, 5'h00);
            tick();
            chk($sformatf("frame%0d_active", k), 8'(bus.flash_active), 8'(k < 2 * FF * FC));
            drive(1, 0, 0, 5'h03, 1, 5'h09, 1, 5'h0A);
            tick();
            chk($sformatf("frame%0d_sprite", k), 8'(bus.memMappedValue), on ? 8'h06 : 8'h09);
            idle();
            tick();
            chk($sformatf("frame%0d_bullet", k), 8'(bus.memMappedValue), 8'h0A);
            tick();
        end

        // flash_req together with frame_start starts immediately; then reset mid FLASH_ON.
        drive(0, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0);
        tick();
        chk("same_edge_start", 8'(bus.flash_active), 8'd1);
        drive(1, 0, 0, 5'h03, 1, 5'h09, 0, 5'd0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        chk("mid_rst_active", 8'(bus.flash_active), 8'd0);
        chk("mid_rst_valid", 8'(bus.out_valid), 8'd0);
        Reset = 1'b0;
        drive(1, 0, 0, 5'h03, 1, 5'h09, 0, 5'd0);
        tick();
        chk("after_rst_c1_valid", 8'(bus.out_valid), 8'd0);
        drive(1, 0, 0, 5'h04, 0, 5'd0, 0, 5'd0);
        tick();
        chk("after_rst_px1", 8'(bus.memMappedValue), 8'h09);
        idle();
        tick();
        chk("after_rst_px2", 8'(bus.memMappedValue), 8'h04);
        chk("after_rst_px2_valid", 8'(bus.out_valid), 8'd1);

        // Randomized run checked against the reference model on every cycle.
        for (int c = 0; c < 3000; c++) begin
            Reset           = ($urandom_range(0, 399) == 0);
            bus.pixel_en    = ($urandom_range(0, 3) != 0);
            bus.frame_start = ($urandom_range(0, 5) == 0);
            bus.flash_req   = ($urandom_range(0, 19) == 0);
            bus.bg_index    = ($urandom_range(0, 99) < 2) ? 5'h1F : 5'($urandom_range(0, 21));
            bus.spr_valid   = 1'($urandom_range(0, 1));
            bus.spr_index   = ($urandom_range(0, 99) < 2) ? 5'h17 : 5'($urandom_range(0, 21));
            bus.blt_valid   = ($urandom_range(0, 3) == 0);
            bus.blt_index   = 5'($urandom_range(0, 21));
            tick();
        end
        Reset = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_layer_scheduler.md
Name: pixel_layer_scheduler

Overview:
- Per-pixel layer arbiter and effect sequencer that feeds the 5-bit palette index input of the fixed colour mapper.
- Merges the background, player-sprite and bullet layers by priority, treating index 0 as transparent on the sprite and bullet layers.
- Applies a frame-timed hit-flash effect that replaces sprite pixels with white.
- Sits between the VGA pixel fetch logic and the colour mapper. Fixed 2-cycle pipeline.

Parameters:
- MAX_INDEX, 5'h15, highest legal palette index; any index above it is treated as out of range.
- FLASH_INDEX, 5'h06, palette index forced onto sprite pixels during the flash-on phase (white).
- FLASH_FRAMES, 4, number of frames in each flash-on phase and in each flash-off phase (range 1..15).
- FLASH_CYCLES, 3, number of on/off pairs per flash event (range 1..7).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- pixel_en  in  1  a valid pixel is presented this cycle.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- bg_index  in  5  background layer index; always valid when pixel_en is high.
- spr_valid  in  1  sprite layer covers this pixel.
- spr_index  in  5  sprite layer index.
- blt_valid  in  1  bullet layer covers this pixel.
- blt_index  in  5  bullet layer index.
- flash_req  in  1  one-cycle request to start a flash event.
- memMappedValue  out  5  resolved palette index sent to the colour mapper.
- out_valid  out  1  memMappedValue holds a pixel this cycle.
- flash_active  out  1  high while the flash FSM is not IDLE.
- range_err  out  1  sticky out-of-range index flag.

Behaviour:
- Reset: memMappedValue=0, out_valid=0, flash_active=0, range_err=0, FSM=IDLE, all counters=0, pending=0, both pipeline stages invalid.
- Pipeline advances every Clk; there is no stall.
- Stage 1 registers pixel_en and all layer inputs.
- Stage 2 resolves the pixel and registers memMappedValue and out_valid.
- A pixel presented with pixel_en at cycle N appears with out_valid=1 at cycle N+2.
- When out_valid=0, memMappedValue holds its last value.
- Priority:
  - Bullet wins if blt_valid=1 and blt_index!=0.
  - Otherwise sprite wins if spr_valid=1 and spr_index!=0.
  - Otherwise background wins; bg_index=0 passes through as black.
- Range check is done in stage 2 on the winning index only. If it exceeds MAX_INDEX, output 0 and set range_err. range_err is cleared only by Reset.
- Flash override: when the sprite layer wins and the FSM is in FLASH_ON at stage-2 evaluation, output FLASH_INDEX.
  - The override applies after the range check.
  - Bullet and background pixels are never overridden.
- Flash FSM states: IDLE, FLASH_ON, FLASH_OFF.
  - flash_req in IDLE sets pending=1.
  - flash_req outside IDLE, or while pending=1, is ignored.
  - IDLE -> FLASH_ON on frame_start when pending=1 (or when flash_req=1 in the same cycle). Clears pending and sets frm_cnt=0 and cyc_cnt=0.
  - In FLASH_ON or FLASH_OFF, each frame_start increments frm_cnt.
  - On the frame_start where frm_cnt==FLASH_FRAMES-1: set frm_cnt=0 and change phase.
    - FLASH_ON -> FLASH_OFF.
    - FLASH_OFF -> FLASH_ON with cyc_cnt+1, or -> IDLE if cyc_cnt==FLASH_CYCLES-1.
- flash_active is registered and equals (state != IDLE).
- Total event length is 2*FLASH_FRAMES*FLASH_CYCLES frames (24 with defaults).
- Simultaneous events:
  - When frame_start and pixel_en arrive in the same cycle, that pixel is resolved with the state held after that edge, i.e. the new phase.
  - flash_req and frame_start together in IDLE start FLASH_ON on that edge.
- Reset mid-event returns the FSM to IDLE immediately, drops any pending request, and invalidates both stages. out_valid=0 for 2 cycles after Reset deasserts, even if pixel_en=1.

Test Plan:
- Reset, then pixel_en=1 with bg=5'h05 and spr/blt invalid at cycle 0 -> cycle 2: out_valid=1, memMappedValue=5'h05; cycles 0–1: out_valid=0.
- bg=5'h03, spr_valid=1 spr=5'h09, blt_valid=1 blt=5'h00 -> 5'h09 (bullet transparent); then blt=5'h0A -> 5'h0A; then spr=5'h00 with blt_valid=0 -> 5'h03.
- Winning index 5'h1F -> memMappedValue=5'h00, range_err=1; following legal pixels output normally; range_err stays 1 until Reset.
- Pulse flash_req mid-frame, then at the next frame_start -> flash_active=1; sprite pixel 5'h09 outputs 5'h06 for 4 frames, then 5'h09 for 4 frames; 3 pairs, then IDLE after 24 frame_starts; bullet 5'h0A is unchanged throughout.
- Second flash_req during FLASH_OFF -> ignored; IDLE is still reached on the 24th frame_start from the start of the event.
- Reset asserted during FLASH_ON with pixels in flight -> next cycle: flash_active=0, out_valid=0; two pixels after Reset deasserts output normally with latency 2.
